// File: rtl/cla_serial_adder.sv
// Nibble-serial adder: one 4-bit carry-lookahead generator is reused
// across WIDTH/4 slices, with the slice carry-out registered between cycles.
// Operands arrive on a valid/ready handshake and the result leaves on another.

// 4-bit carry-lookahead generator: propagate and all slice carries from A, B, Cin.
module carry_lookahead_generator (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] p,
    output logic [4:0] c
);
    logic [3:0] g;

    assign p    = a ^ b;
    assign g    = a & b;
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
endmodule

module cla_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] KLAST = KW'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cin_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             ovf_reg;

    logic [3:0]       sl_a;
    logic [3:0]       sl_b;
    logic [3:0]       sl_p;
    logic [4:0]       sl_c;
    logic             sl_cin;

    // Select the operand nibbles and carry-in for the slice currently being processed.
    always_comb begin
        sl_a = '0;
        sl_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                sl_a = a_reg[4*i +: 4];
                sl_b = b_reg[4*i +: 4];
            end
        end
        sl_cin = (k == '0) ? cin_reg : carry_reg;
    end

    carry_lookahead_generator u_cla (
        .a   (sl_a),
        .b   (sl_b),
        .cin (sl_cin),
        .p   (sl_p),
        .c   (sl_c)
    );

    // Handshake FSM plus per-slice sum/carry registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            carry_reg <= 1'b0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        cin_reg <= cin;
                        k       <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < N; i++) begin
                        if (k == KW'(i)) begin
                            sum_reg[4*i +: 4] <= sl_p ^ sl_c[3:0];
                        end
                    end
                    carry_reg <= sl_c[4];
                    if (k == KLAST) begin
                        cout_reg <= sl_c[4];
                        ovf_reg  <= sl_c[3] ^ sl_c[4];
                        state    <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign overflow  = ovf_reg;
endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed bench for cla_serial_adder: a WIDTH=16 instance driven from a
// vector table plus hand-written backpressure/reset sequences, and a
// WIDTH=4 instance for the single-slice case.
module tb_cla_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, ci16 = 1'b0, co16, of16;
    logic [15:0] a16 = '0, b16 = '0, s16;

    // WIDTH=4 instance
    logic        iv4 = 1'b0, ir4, ov4, or4 = 1'b0, ci4 = 1'b0, co4, of4;
    logic [3:0]  a4 = '0, b4 = '0, s4;

    cla_serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .cin(ci16), .out_valid(ov16), .out_ready(or16),
        .sum(s16), .cout(co16), .overflow(of16)
    );

    cla_serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .a(a4), .b(b4), .cin(ci4), .out_valid(ov4), .out_ready(or4),
        .sum(s4), .cout(co4), .overflow(of4)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec16_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
        logic       ovf;
    } vec4_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Full transaction on the 16-bit instance; checks latency, result and return to IDLE.
    task automatic run16(input vec16_t v, input string name);
        int cyc;
        @(negedge clk);
        check({name, ".in_ready"}, 32'(ir16), 32'd1);
        a16 = v.a; b16 = v.b; ci16 = v.cin; iv16 = 1'b1; or16 = 1'b0;
        @(posedge clk); #1;
        iv16 = 1'b0; a16 = 16'hDEAD; b16 = 16'hBEEF; ci16 = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!ov16 && cyc < 20);
        check({name, ".latency"}, 32'(cyc), 32'd4);
        check({name, ".sum"}, 32'(s16), 32'(v.sum));
        check({name, ".cout"}, 32'(co16), 32'(v.cout));
        check({name, ".ovf"}, 32'(of16), 32'(v.ovf));
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        check({name, ".ready_after"}, 32'(ir16), 32'd1);
        check({name, ".valid_after"}, 32'(ov16), 32'd0);
    endtask

    // Full transaction on the 4-bit instance.
    task automatic run4(input vec4_t v, input string name);
        int cyc;
        @(negedge clk);
        a4 = v.a; b4 = v.b; ci4 = v.cin; iv4 = 1'b1; or4 = 1'b0;
        @(posedge clk); #1;
        iv4 = 1'b0; a4 = 4'h0; b4 = 4'h0; ci4 = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!ov4 && cyc < 20);
        check({name, ".latency"}, 32'(cyc), 32'd1);
        check({name, ".sum"}, 32'(s4), 32'(v.sum));
        check({name, ".cout"}, 32'(co4), 32'(v.cout));
        check({name, ".ovf"}, 32'(of4), 32'(v.ovf));
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
        check({name, ".ready_after"}, 32'(ir4), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec16_t v16 [8];
        vec4_t  v4 [3];
        vec16_t bp;
        logic [15:0] held_sum;
        logic        held_cout, held_ovf;
        int cyc;

        v16[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        v16[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        v16[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        v16[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        v16[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        v16[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        v16[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
        v16[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        v4[0] = '{4'hA, 4'hC, 1'b1, 4'h7, 1'b1, 1'b1};
        v4[1] = '{4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1};
        v4[2] = '{4'h3, 4'h4, 1'b1, 4'h8, 1'b0, 1'b1};

        // Reset state
        #12;
        check("rst.in_ready16", 32'(ir16), 32'd1);
        check("rst.out_valid16", 32'(ov16), 32'd0);
        check("rst.sum16", 32'(s16), 32'd0);
        check("rst.cout16", 32'(co16), 32'd0);
        check("rst.ovf16", 32'(of16), 32'd0);
        check("rst.in_ready4", 32'(ir4), 32'd1);
        check("rst.out_valid4", 32'(ov4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run16(v16[i], $sformatf("vec16_%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            run4(v4[i], $sformatf("vec4_%0d", i));
        end

        // Backpressure with ignored in_valid pulses during RUN and DONE
        @(negedge clk);
        a16 = 16'h1111; b16 = 16'h2222; ci16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;   // stays valid through RUN
        check("bp.ready_run", 32'(ir16), 32'd0);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!ov16 && cyc < 20);
        check("bp.latency", 32'(cyc), 32'd4);
        check("bp.sum", 32'(s16), 32'h3333);
        held_sum = s16; held_cout = co16; held_ovf = of16;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp.hold_valid", 32'(ov16), 32'd1);
            check("bp.hold_ready", 32'(ir16), 32'd0);
            check("bp.hold_sum", 32'(s16), 32'h3333);
            check("bp.hold_flags", {30'd0, co16, of16}, {30'd0, held_cout, held_ovf});
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        @(posedge clk); #1;
        or16 = 1'b0;
        check("bp.ready_after", 32'(ir16), 32'd1);
        check("bp.sum_kept", 32'(s16), 32'(held_sum));
        bp = '{16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, 1'b0};
        run16(bp, "bp.next");

        // Reset asserted mid-RUN at slice k=2
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0001; ci16 = 1'b0; iv16 = 1'b1;
        @(posedge clk); #1;           // E0: accepted
        iv16 = 1'b0;
        @(posedge clk); #1;           // E1
        @(posedge clk); #1;           // E2: now processing k=2
        check("mid.ready_run", 32'(ir16), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("mid.in_ready", 32'(ir16), 32'd1);
        check("mid.out_valid", 32'(ov16), 32'd0);
        check("mid.sum", 32'(s16), 32'd0);
        check("mid.cout_ovf", {30'd0, co16, of16}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run16(v16[7], "mid.after");

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
